// File: rtl/dp_arbiter_if.sv
// Signal bundle shared by the requester FSMs, the datapath arbiter and the datapath.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface dp_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int INSTR_W  = 32,
    parameter int RESULT_W = 32
);
    logic [NUM_REQ-1:0]          req_start;
    logic [NUM_REQ*INSTR_W-1:0]  req_instruction;
    logic [NUM_REQ-1:0]          req_finished;
    logic [NUM_REQ*RESULT_W-1:0] req_result;
    logic                        start_dp;
    logic [INSTR_W-1:0]          instruction_dp;
    logic                        finished_dp;
    logic [RESULT_W-1:0]         result_dp;

    modport slave (
        input  req_start,
        input  req_instruction,
        output req_finished,
        output req_result,
        output start_dp,
        output instruction_dp,
        input  finished_dp,
        input  result_dp
    );

    modport master (
        output req_start,
        output req_instruction,
        input  req_finished,
        input  req_result,
        input  start_dp,
        input  instruction_dp,
        output finished_dp,
        output result_dp
    );
endinterface

// File: rtl/dp_arbiter.sv
// Round-robin arbiter sharing one datapath among NUM_REQ sequencing FSMs, presenting
// each requester the same start/finished/result handshake the datapath itself offers.
module dp_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int INSTR_W  = 32,
    parameter int RESULT_W = 32
) (
    input logic         clock,
    input logic         resetn,
    dp_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  pending_q;
    logic [NUM_REQ-1:0]  pending_d;
    logic [NUM_REQ-1:0]  finished_q;
    logic [NUM_REQ-1:0]  finished_d;
    logic [NUM_REQ-1:0]  capture;
    logic [IDX_W-1:0]    grant_q;
    logic [IDX_W-1:0]    last_q;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    scanIdx;
    logic                found;
    logic                complete;
    logic                start_q;
    logic [INSTR_W-1:0]  instr_q;
    logic [INSTR_W-1:0]  instrSlice [NUM_REQ];
    logic [RESULT_W-1:0] result_q   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slices
        assign instrSlice[i]                             = bus.req_instruction[i*INSTR_W +: INSTR_W];
        assign bus.req_result[i*RESULT_W +: RESULT_W]    = result_q[i];
    end

    assign bus.req_finished   = finished_q;
    assign bus.start_dp       = start_q;
    assign bus.instruction_dp = instr_q;

    // A start only counts while the requester looks idle, so a held or early start is dropped.
    assign capture  = bus.req_start & finished_q;
    assign complete = (state_q == WAIT) && bus.finished_dp;

    always_comb begin
        winner  = last_q;
        scanIdx = last_q;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scanIdx = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && pending_q[scanIdx]) begin
                winner = scanIdx;
                found  = 1'b1;
            end
        end
    end

    // The granted requester cannot be captured here since its finished flag is still low.
    always_comb begin
        pending_d  = pending_q | capture;
        finished_d = finished_q & ~capture;
        if (complete) begin
            pending_d[grant_q]  = 1'b0;
            finished_d[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            instr_q    <= '0;
            pending_q  <= '0;
            finished_q <= '1;
            grant_q    <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            finished_q <= finished_d;
            case (state_q)
                IDLE: begin
                    if (|pending_q) begin
                        instr_q <= instrSlice[winner];
                        start_q <= 1'b1;
                        grant_q <= winner;
                        last_q  <= winner;
                        state_q <= HOLD;
                    end else begin
                        start_q <= 1'b0;
                    end
                end
                HOLD: begin
                    start_q <= 1'b1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    start_q <= 1'b0;
                    if (bus.finished_dp) begin
                        result_q[grant_q] <= bus.result_dp;
                        state_q           <= IDLE;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dp_arbiter.sv
// Directed bench for dp_arbiter with a 5-cycle datapath model that returns instruction+1.
module tb_dp_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int INSTR_W    = 32;
    localparam int RESULT_W   = 32;
    localparam int DP_LATENCY = 5;

    logic clock;
    logic resetn;
    int   vectors;
    int   miscompares;
    int   dpCount;
    logic [INSTR_W-1:0] dpInstr;
    logic prevStart;
    int   runLen;
    logic [INSTR_W-1:0] grantLog [$];
    logic [INSTR_W-1:0] expOrder [10];

    dp_arbiter_if #(.NUM_REQ(NUM_REQ), .INSTR_W(INSTR_W), .RESULT_W(RESULT_W)) bus ();

    dp_arbiter #(.NUM_REQ(NUM_REQ), .INSTR_W(INSTR_W), .RESULT_W(RESULT_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Datapath model: accepts a start while idle, reports finished DP_LATENCY edges later.
    always @(posedge clock) begin
        if (!resetn) begin
            bus.finished_dp <= 1'b1;
            bus.result_dp   <= '0;
            dpCount         <= 0;
            dpInstr         <= '0;
        end else if (bus.finished_dp && bus.start_dp) begin
            bus.finished_dp <= 1'b0;
            dpCount         <= DP_LATENCY;
            dpInstr         <= bus.instruction_dp;
        end else if (!bus.finished_dp) begin
            if (dpCount == 1) begin
                bus.finished_dp <= 1'b1;
                bus.result_dp   <= dpInstr + 1;
            end else begin
                dpCount <= dpCount - 1;
            end
        end
    end

    // Logs every grant and checks each start pulse is exactly two cycles into an idle datapath.
    always @(negedge clock) begin
        if (!resetn) begin
            prevStart <= 1'b0;
            runLen    <= 0;
        end else begin
            if (bus.start_dp && !prevStart) begin
                grantLog.push_back(bus.instruction_dp);
                checkOutput("dpIdleAtGrant", 64'(bus.finished_dp), 64'd1);
            end
            if (!bus.start_dp && prevStart) begin
                checkOutput("startPulseLen", 64'(runLen), 64'd2);
            end
            runLen    <= bus.start_dp ? runLen + 1 : 0;
            prevStart <= bus.start_dp;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] startMask);
        bus.req_start = startMask;
    endtask

    task automatic setInstr(input int r, input logic [INSTR_W-1:0] v);
        bus.req_instruction[r*INSTR_W +: INSTR_W] = v;
    endtask

    function automatic logic [RESULT_W-1:0] resultOf(input int r);
        return bus.req_result[r*RESULT_W +: RESULT_W];
    endfunction

    task automatic doReset();
        resetn = 1'b0;
        applyStimulus('0);
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (bus.req_finished !== '1 && n < budget) begin
            step();
            n++;
        end
        checkOutput(tag, 64'(bus.req_finished), 64'hF);
    endtask

    task automatic waitGrants(input string tag, input int count, input int budget);
        int n = 0;
        while (grantLog.size() < count && n < budget) begin
            step();
            n++;
        end
        checkOutput(tag, 64'(grantLog.size() >= count), 64'd1);
    endtask

    task automatic checkResultsZero(input string tag);
        for (int r = 0; r < NUM_REQ; r++) begin
            checkOutput(tag, 64'(resultOf(r)), 64'd0);
        end
    endtask

    initial begin
        clock       = 1'b0;
        resetn      = 1'b0;
        vectors     = 0;
        miscompares = 0;
        bus.req_start       = '0;
        bus.req_instruction = '0;

        // Reset state
        doReset();
        checkOutput("rstFinished", 64'(bus.req_finished), 64'hF);
        checkOutput("rstStartDp", 64'(bus.start_dp), 64'd0);
        checkOutput("rstInstrDp", 64'(bus.instruction_dp), 64'd0);
        checkResultsZero("rstResult");

        // Single request, cycle-accurate timeline
        setInstr(0, 32'hA000_0001);
        applyStimulus(4'b0001);
        step();
        checkOutput("t1Finished0Edge1", 64'(bus.req_finished[0]), 64'd0);
        checkOutput("t1StartDpEdge1", 64'(bus.start_dp), 64'd0);
        step();
        applyStimulus('0);
        checkOutput("t1StartDpEdge2", 64'(bus.start_dp), 64'd1);
        checkOutput("t1InstrDp", 64'(bus.instruction_dp), 64'hA000_0001);
        step();
        checkOutput("t1StartDpEdge3", 64'(bus.start_dp), 64'd1);
        step();
        checkOutput("t1StartDpEdge4", 64'(bus.start_dp), 64'd0);
        checkOutput("t1FinishedDpEdge4", 64'(bus.finished_dp), 64'd0);
        for (int i = 0; i < 4; i++) step();
        checkOutput("t1FinishedDpEdge8", 64'(bus.finished_dp), 64'd1);
        checkOutput("t1Finished0Edge8", 64'(bus.req_finished[0]), 64'd0);
        step();
        checkOutput("t1Finished0Edge9", 64'(bus.req_finished[0]), 64'd1);
        checkOutput("t1Result0", 64'(resultOf(0)), 64'hA000_0002);
        checkOutput("t1InstrDpHeld", 64'(bus.instruction_dp), 64'hA000_0001);

        // All four at once from reset priority
        doReset();
        grantLog.delete();
        for (int r = 0; r < NUM_REQ; r++) setInstr(r, 32'hB000_0000 + r);
        applyStimulus(4'b1111);
        step();
        step();
        applyStimulus('0);
        waitIdle("t2Idle", 200);
        checkOutput("t2GrantCount", 64'(grantLog.size()), 64'd4);
        for (int r = 0; r < NUM_REQ; r++) begin
            checkOutput("t2GrantOrder", 64'(grantLog[r]), 64'(32'hB000_0000 + r));
            checkOutput("t2Result", 64'(resultOf(r)), 64'(32'hB000_0001 + r));
        end

        // Fairness with continuous re-requests, requester 0 joining mid-stream
        grantLog.delete();
        for (int r = 0; r < 3; r++) setInstr(r, 32'hC000_0000 + r);
        applyStimulus(4'b0110);
        waitGrants("t3FirstFive", 5, 200);
        applyStimulus(4'b0111);
        waitGrants("t3FirstTen", 10, 300);
        applyStimulus('0);
        waitIdle("t3Idle", 200);
        expOrder = '{32'hC000_0001, 32'hC000_0002, 32'hC000_0001, 32'hC000_0002, 32'hC000_0001,
                     32'hC000_0002, 32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0000};
        for (int g = 0; g < 10; g++) begin
            checkOutput("t3GrantOrder", 64'(grantLog[g]), 64'(expOrder[g]));
        end
        for (int r = 0; r < 3; r++) begin
            checkOutput("t3Result", 64'(resultOf(r)), 64'(32'hC000_0001 + r));
        end

        // Held start yields exactly one transaction
        grantLog.delete();
        setInstr(3, 32'hD000_0003);
        applyStimulus(4'b1000);
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("t4HeldFinished3", 64'(bus.req_finished[3]), 64'd0);
        end
        applyStimulus('0);
        waitIdle("t4Idle", 100);
        checkOutput("t4GrantCount", 64'(grantLog.size()), 64'd1);
        checkOutput("t4Grant", 64'(grantLog[0]), 64'hD000_0003);
        checkOutput("t4Result3", 64'(resultOf(3)), 64'hD000_0004);

        // Reset while waiting on the datapath
        grantLog.delete();
        setInstr(1, 32'hE000_0001);
        applyStimulus(4'b0010);
        step();
        step();
        applyStimulus('0);
        step();
        step();
        checkOutput("t5PreStartDp", 64'(bus.start_dp), 64'd0);
        checkOutput("t5PreFinished1", 64'(bus.req_finished[1]), 64'd0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checkOutput("t5RstStartDp", 64'(bus.start_dp), 64'd0);
        checkOutput("t5RstFinished", 64'(bus.req_finished), 64'hF);
        checkOutput("t5RstInstrDp", 64'(bus.instruction_dp), 64'd0);
        checkResultsZero("t5RstResult");
        for (int i = 0; i < 4; i++) step();
        checkOutput("t5NoRegrant", 64'(grantLog.size()), 64'd1);
        setInstr(2, 32'hE000_0002);
        applyStimulus(4'b0100);
        step();
        step();
        applyStimulus('0);
        waitIdle("t5Idle", 100);
        checkOutput("t5Grant2", 64'(grantLog[1]), 64'hE000_0002);
        checkOutput("t5Result2", 64'(resultOf(2)), 64'hE000_0003);
        checkOutput("t5Result1Aborted", 64'(resultOf(1)), 64'd0);

        // Completion of requester 1 on the same edge requester 2 is captured
        setInstr(1, 32'hF000_0001);
        applyStimulus(4'b0010);
        step();
        step();
        applyStimulus('0);
        for (int i = 0; i < 6; i++) step();
        checkOutput("t6FinishedDpEdge8", 64'(bus.finished_dp), 64'd1);
        checkOutput("t6Finished1Edge8", 64'(bus.req_finished[1]), 64'd0);
        setInstr(2, 32'hF000_0002);
        applyStimulus(4'b0100);
        step();
        checkOutput("t6Finished1Edge9", 64'(bus.req_finished[1]), 64'd1);
        checkOutput("t6Result1", 64'(resultOf(1)), 64'hF000_0002);
        checkOutput("t6Finished2Edge9", 64'(bus.req_finished[2]), 64'd0);
        checkOutput("t6StartDpEdge9", 64'(bus.start_dp), 64'd0);
        step();
        applyStimulus('0);
        checkOutput("t6StartDpEdge10", 64'(bus.start_dp), 64'd1);
        checkOutput("t6InstrDpEdge10", 64'(bus.instruction_dp), 64'hF000_0002);
        waitIdle("t6Idle", 100);
        checkOutput("t6Result2", 64'(resultOf(2)), 64'hF000_0003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
